// File: rtl/stream_array_replay_pkg.sv
// Shared types for the stream-to-array replay block.
// FSM encoding, default widths and the array request/response bundle.
package stream_array_replay_pkg;

    localparam int unsigned N_DEF     = 8;
    localparam int unsigned A_DEF     = 8;
    localparam int unsigned DEPTH_DEF = 16;

    typedef logic [N_DEF-1:0] int_t;
    typedef logic [A_DEF-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic  valid;
        logic  we;
        addr_t addr;
        int_t  di;
    } arr_req_t;

    typedef struct packed {
        logic ready;
        int_t dout;
    } arr_rsp_t;

    function automatic logic [31:0] clamp_len(
        input logic [31:0] l,
        input logic [31:0] d
    );
        return (l > d) ? d : l;
    endfunction

endpackage

// File: rtl/stream_array_replay_obuf.sv
// One-entry output register with simultaneous load and unload.
// A load always wins, so a word read in the same cycle one leaves is kept.
module stream_obuf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         unload,
    output logic [W-1:0] dout,
    output logic         full
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            data_d = din;
        end else if (unload) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign dout = data_q;
    assign full = full_q;

endmodule

// File: rtl/stream_array_replay.sv
// Captures a burst from sIn into an external array, then replays it
// on sOut in forward or reverse order; started/completed via sync handshakes.
module stream_array_replay
    import stream_array_replay_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned A     = A_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned BASE  = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    input  logic [A-1:0] len,
    input  logic         rev,
    input  logic [N-1:0] sIn,
    input  logic         sIn_valid,
    output logic         sIn_ready,
    output logic [N-1:0] sOut,
    output logic         sOut_valid,
    input  logic         sOut_ready,
    output logic [A-1:0] arr_addr,
    output logic         arr_we,
    output logic [N-1:0] arr_di,
    output logic         arr_valid,
    input  logic [N-1:0] arr_do,
    input  logic         arr_ready,
    output logic [A-1:0] count
);

    localparam logic [A-1:0] BASE_A = A'(BASE);
    localparam logic [A-1:0] ONE_A  = A'(1);

    state_e       state_q, state_d;
    logic [A-1:0] idx_q, idx_d;
    logic [A-1:0] cnt_q, cnt_d;
    logic [A-1:0] len_q, len_d;
    logic         rev_q, rev_d;

    logic [A-1:0] len_clamp;
    logic [A-1:0] idx_inc;
    logic         rd_pend;
    logic         wr_fire;
    logic         rd_fire;
    logic         obuf_full;

    assign len_clamp = A'(clamp_len(32'(len), 32'(DEPTH)));
    assign idx_inc   = idx_q + ONE_A;
    assign rd_pend   = (idx_q != len_q);

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        sIn_ready = 1'b0;
        arr_valid = 1'b0;
        arr_we    = 1'b0;
        arr_addr  = BASE_A;
        arr_di    = '0;
        unique case (state_q)
            ST_IDLE: ;
            ST_FILL: begin
                arr_valid = sIn_valid;
                arr_we    = 1'b1;
                arr_addr  = BASE_A + idx_q;
                arr_di    = sIn;
                sIn_ready = arr_ready;
            end
            ST_DRAIN: begin
                // Stop reading once all L words have been fetched.
                arr_valid = rd_pend && (!obuf_full || sOut_ready);
                arr_addr  = rev_q ? (BASE_A + len_q - ONE_A - idx_q)
                                  : (BASE_A + idx_q);
            end
            ST_DONE: ;
        endcase
    end

    assign wr_fire = (state_q == ST_FILL) && arr_valid && arr_ready;
    assign rd_fire = (state_q == ST_DRAIN) && arr_valid && arr_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        rev_d   = rev_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    len_d   = len_clamp;
                    rev_d   = rev;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = (len_clamp != '0) ? ST_FILL : ST_DONE;
                end
            end
            ST_FILL: begin
                if (wr_fire) begin
                    cnt_d = cnt_q + ONE_A;
                    if (idx_inc == len_q) begin
                        idx_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            ST_DRAIN: begin
                if (rd_fire) begin
                    idx_d = idx_inc;
                end
                // Leave on the edge where the last buffered word is taken.
                if (!rd_pend && (!obuf_full || sOut_ready)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            rev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            rev_q   <= rev_d;
        end
    end

    stream_obuf #(
        .W(N)
    ) u_obuf (
        .clk   (clk),
        .rst   (rst),
        .load  (rd_fire),
        .din   (arr_do),
        .unload(sOut_ready),
        .dout  (sOut),
        .full  (obuf_full)
    );

    assign sOut_valid = obuf_full;
    assign count      = cnt_q;

endmodule

// File: tb/tb_stream_array_replay.sv
// Bench for stream_array_replay: two instances (BASE 0 and 250) in lockstep,
// each backed by its own array model, with queue-based expectations.
module tb_stream_array_replay;

    localparam int B0 = 0;
    localparam int B1 = 250;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic out_ready;
    logic [7:0] len;
    logic rev;
    logic [7:0] sIn;
    logic sIn_valid;
    logic sOut_ready;
    logic arr_ready;

    logic [1:0]      in_ready, out_valid, sIn_ready, sOut_valid;
    logic [1:0]      arr_we, arr_valid;
    logic [1:0][7:0] sOut, arr_addr, arr_di, arr_do, count;

    logic [7:0] mem [2][256];

    int q_wa  [2][$];
    int q_ra  [2][$];
    int q_out [2][$];

    int out_seen [2];
    int done_cnt [2];
    int first_cyc[2];
    int last_cyc [2];
    int cyc = 0;

    int n_chk  = 0;
    int n_fail = 0;

    bit rdy_mode = 1'b0;
    int stall_n  = 0;

    always #5 clk = ~clk;

    stream_array_replay #(
        .N(8), .A(8), .DEPTH(16), .BASE(B0)
    ) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .len(len), .rev(rev),
        .sIn(sIn), .sIn_valid(sIn_valid), .sIn_ready(sIn_ready[0]),
        .sOut(sOut[0]), .sOut_valid(sOut_valid[0]), .sOut_ready(sOut_ready),
        .arr_addr(arr_addr[0]), .arr_we(arr_we[0]), .arr_di(arr_di[0]),
        .arr_valid(arr_valid[0]), .arr_do(arr_do[0]), .arr_ready(arr_ready),
        .count(count[0])
    );

    stream_array_replay #(
        .N(8), .A(8), .DEPTH(16), .BASE(B1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .len(len), .rev(rev),
        .sIn(sIn), .sIn_valid(sIn_valid), .sIn_ready(sIn_ready[1]),
        .sOut(sOut[1]), .sOut_valid(sOut_valid[1]), .sOut_ready(sOut_ready),
        .arr_addr(arr_addr[1]), .arr_we(arr_we[1]), .arr_di(arr_di[1]),
        .arr_valid(arr_valid[1]), .arr_do(arr_do[1]), .arr_ready(arr_ready),
        .count(count[1])
    );

    assign arr_do[0] = mem[0][arr_addr[0]];
    assign arr_do[1] = mem[1][arr_addr[1]];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int base_of(input int k);
        return (k == 0) ? B0 : B1;
    endfunction

    // Array model and output scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (arr_valid[k] && arr_ready) begin
                if (arr_we[k]) begin
                    mem[k][arr_addr[k]] = arr_di[k];
                    if (q_wa[k].size() == 0) chk("extra_write", 1, 0);
                    else chk("wr_addr", int'(arr_addr[k]), q_wa[k].pop_front());
                end else begin
                    if (q_ra[k].size() == 0) chk("extra_read", 1, 0);
                    else chk("rd_addr", int'(arr_addr[k]), q_ra[k].pop_front());
                end
            end
            if (sOut_valid[k] && sOut_ready) begin
                if (q_out[k].size() == 0) chk("extra_out", 1, 0);
                else chk("sout", int'(sOut[k]), q_out[k].pop_front());
                if (out_seen[k] == 0) first_cyc[k] = cyc;
                last_cyc[k] = cyc;
                out_seen[k]++;
            end
            if (out_valid[k] && out_ready) done_cnt[k]++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            arr_ready = rdy_mode ? ~arr_ready : 1'b1;
            if (stall_n > 0) begin
                sOut_ready = 1'b0;
                stall_n--;
            end else begin
                sOut_ready = 1'b1;
            end
        end
    end

    task automatic chk_rst();
        for (int k = 0; k < 2; k++) begin
            chk("rst_in_ready", int'(in_ready[k]), 1);
            chk("rst_out_valid", int'(out_valid[k]), 0);
            chk("rst_sin_ready", int'(sIn_ready[k]), 0);
            chk("rst_sout_valid", int'(sOut_valid[k]), 0);
            chk("rst_arr_valid", int'(arr_valid[k]), 0);
            chk("rst_arr_we", int'(arr_we[k]), 0);
            chk("rst_arr_addr", int'(arr_addr[k]), base_of(k));
            chk("rst_arr_di", int'(arr_di[k]), 0);
            chk("rst_count", int'(count[k]), 0);
        end
    endtask

    task automatic push_exp(input int l, input bit r, input int d0, output int lc);
        lc = (l > 16) ? 16 : l;
        for (int k = 0; k < 2; k++) begin
            out_seen[k] = 0;
            done_cnt[k] = 0;
            for (int i = 0; i < lc; i++) begin
                q_wa[k].push_back((base_of(k) + i) % 256);
                q_ra[k].push_back(r ? (base_of(k) + lc - 1 - i) % 256
                                    : (base_of(k) + i) % 256);
                q_out[k].push_back((r ? d0 + lc - 1 - i : d0 + i) % 256);
            end
        end
    endtask

    task automatic start_burst(input int l, input bit r);
        in_valid = 1'b1;
        len = l[7:0];
        rev = r;
        @(negedge clk);
        chk("start_in_ready", int'(in_ready[0]), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        len = 8'($urandom);
        rev = ~r;
    endtask

    task automatic feed(input int lc, input int d0);
        int i = 0;
        int t = 0;
        while (i < lc && t < 500) begin
            sIn = 8'(d0 + i);
            sIn_valid = 1'b1;
            @(negedge clk);
            if (sIn_ready[0]) i++;
            @(posedge clk);
            #1;
            t++;
        end
        sIn_valid = 1'b0;
        chk("fill_words", i, lc);
    endtask

    task automatic finish_burst(input int lc, input bit tight);
        int t = 0;
        out_ready = 1'b1;
        while (done_cnt[0] == 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("done_once", done_cnt[k], 1);
            chk("count", int'(count[k]), lc);
            chk("out_words", out_seen[k], lc);
            chk("back_idle", int'(in_ready[k]), 1);
            if (tight && lc > 0)
                chk("drain_gap", last_cyc[k] - first_cyc[k], lc - 1);
        end
    endtask

    task automatic run_burst(input int l, input bit r, input int d0,
                             input int stall_at, input bit tight);
        int lc;
        int t = 0;
        push_exp(l, r, d0, lc);
        start_burst(l, r);
        feed(lc, d0);
        if (stall_at > 0) begin
            while (out_seen[0] < stall_at && t < 500) begin
                @(posedge clk);
                #1;
                t++;
            end
            stall_n = 5;
        end
        finish_burst(lc, tight);
    endtask

    initial begin
        int lc;
        int t;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        len = '0;
        rev = 1'b0;
        sIn = '0;
        sIn_valid = 1'b0;
        sOut_ready = 1'b1;
        arr_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            out_seen[k] = 0;
            done_cnt[k] = 0;
            first_cyc[k] = 0;
            last_cyc[k] = 0;
            for (int a = 0; a < 256; a++) mem[k][a] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_burst(4, 1'b0, 10, 0, 1'b1);
        run_burst(5, 1'b1, 1, 0, 1'b1);
        run_burst(0, 1'b0, 0, 0, 1'b0);
        run_burst(20, 1'b0, 100, 0, 1'b1);

        rdy_mode = 1'b1;
        run_burst(3, 1'b0, 7, 1, 1'b0);
        rdy_mode = 1'b0;
        @(posedge clk);
        #1;

        push_exp(4, 1'b0, 20, lc);
        start_burst(4, 1'b0);
        feed(lc, 20);
        t = 0;
        while (out_seen[0] < 2 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("pre_reset_words", out_seen[0] >= 2 ? 1 : 0, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_rst();
        for (int k = 0; k < 2; k++) begin
            q_wa[k].delete();
            q_ra[k].delete();
            q_out[k].delete();
        end
        @(posedge clk);
        #1;
        run_burst(2, 1'b0, 30, 0, 1'b1);

        run_burst(8, 1'b0, 50, 0, 1'b1);
        run_burst(8, 1'b1, 60, 0, 1'b1);

        for (int k = 0; k < 2; k++) begin
            chk("wr_q_left", q_wa[k].size(), 0);
            chk("rd_q_left", q_ra[k].size(), 0);
            chk("out_q_left", q_out[k].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
